adc_scan_scheduler: RTL

//  Round-robin scan controller for the 8-input ADC0808. Drives ADD A/B/C, ALE, START and OE,

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_rr_picker.sv | 31 +++
 rtl/adc_scan_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC0808 scan scheduler.
package adc_pkg;
    localparam int ADC_DW = 8;
    localparam int ADC_AW = 3;
    localparam int NUM_CH = 8;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LATCH,
        WAIT_LO,
        WAIT_HI,
        READ,
        DONE
    } adc_state_t;
endpackage

// File: rtl/adc_rr_picker.sv
// Round-robin channel picker: the first enabled channel strictly after last_ch, wrapping.
module adc_rr_picker
    import adc_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [ADC_AW-1:0] last_ch,
    output logic [ADC_AW-1:0] next_ch,
    output logic              any
);
    logic [ADC_AW:0]   sum  [NUM_CH];
    logic [ADC_AW-1:0] cand [NUM_CH];
    logic [NUM_CH-1:0] rot;

    // cand[gi] is the channel gi+1 positions after last_ch; offset NUM_CH lands back on last_ch
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
        assign sum[gi]  = {1'b0, last_ch} + (ADC_AW+1)'(gi + 1);
        assign cand[gi] = (sum[gi] >= (ADC_AW+1)'(NUM_CH))
                        ? ADC_AW'(sum[gi] - (ADC_AW+1)'(NUM_CH))
                        : sum[gi][ADC_AW-1:0];
        assign rot[gi]  = mask[cand[gi]];
    end

    always_comb begin
        next_ch = last_ch;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) next_ch = cand[k];
        end
    end

    assign any = |mask;
endmodule

// File: rtl/adc_scan_scheduler.sv
// ADC0808 round-robin scan controller with per-channel result register file.
// Optional EOC watchdog is enabled by defining ADC_TIMEOUT_EN.
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 2,
    parameter int OE_CYC      = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              eoc,
    input  logic [ADC_DW-1:0] data_in,
    output logic [ADC_AW-1:0] addr,
    output logic              ale,
    output logic              start,
    output logic              oe,
    output logic              res_valid,
    output logic [ADC_AW-1:0] res_ch,
    output logic [ADC_DW-1:0] res_data,
    input  logic [ADC_AW-1:0] rd_ch,
    output logic [ADC_DW-1:0] rd_data,
    output logic              busy,
    output logic              timeout_err
);
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || OE_CYC < 1 || TIMEOUT_CYC < 1 ||
        SETUP_CYC > 256 || PULSE_CYC > 256 || OE_CYC > 256) begin : g_param_check
        $error("adc_scan_scheduler: cycle parameters out of range");
    end

    adc_state_t        state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [ADC_AW-1:0] addr_reg, addr_next;
    logic [ADC_AW-1:0] last_ch_reg, last_ch_next;
    logic              strobe_reg, strobe_next;
    logic              oe_reg, oe_next;
    logic              res_valid_reg, res_valid_next;
    logic [ADC_AW-1:0] res_ch_reg, res_ch_next;
    logic [ADC_DW-1:0] res_data_reg, res_data_next;
    logic              busy_reg;
    logic              wr_en;
    logic [ADC_DW-1:0] regfile_reg [NUM_CH];
    logic [ADC_AW-1:0] pick_ch;
    logic              pick_any;
    logic              tmo_next;

    adc_rr_picker u_picker (
        .mask    (ch_mask),
        .last_ch (last_ch_reg),
        .next_ch (pick_ch),
        .any     (pick_any)
    );

`ifdef ADC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wcnt_reg, wcnt_next;
    logic          tmo_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 8'd1;
        addr_next      = addr_reg;
        last_ch_next   = last_ch_reg;
        strobe_next    = 1'b0;
        oe_next        = 1'b0;
        res_valid_next = 1'b0;
        res_ch_next    = res_ch_reg;
        res_data_next  = res_data_reg;
        wr_en          = 1'b0;
        tmo_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (scan_en && pick_any) begin
                    state_next = SELECT;
                    addr_next  = pick_ch;
                end
            end
            SELECT: begin
                if (cnt_reg == 8'(SETUP_CYC - 1)) begin
                    state_next  = LATCH;
                    cnt_next    = '0;
                    strobe_next = 1'b1;
                end
            end
            LATCH: begin
                strobe_next = 1'b1;
                if (cnt_reg == 8'(PULSE_CYC - 1)) begin
                    state_next  = WAIT_LO;
                    strobe_next = 1'b0;
                end
            end
            WAIT_LO: begin
                cnt_next = '0;
                if (!eoc) state_next = WAIT_HI;
            end
            WAIT_HI: begin
                cnt_next = '0;
                if (eoc) begin
                    state_next = READ;
                    oe_next    = 1'b1;
                end
            end
            READ: begin
                oe_next = 1'b1;
                // Sample on the final OE cycle so the bus has settled for OE_CYC-1 cycles
                if (cnt_reg == 8'(OE_CYC - 1)) begin
                    state_next     = DONE;
                    oe_next        = 1'b0;
                    wr_en          = 1'b1;
                    res_data_next  = data_in;
                    res_ch_next    = addr_reg;
                    res_valid_next = 1'b1;
                end
            end
            DONE: begin
                last_ch_next = addr_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef ADC_TIMEOUT_EN
        wcnt_next = '0;
        if (state_reg == WAIT_LO || (state_reg == WAIT_HI && !eoc)) begin
            if (wcnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                state_next   = IDLE;
                last_ch_next = addr_reg;
                tmo_next     = 1'b1;
            end else begin
                wcnt_next = wcnt_reg + 1'b1;
            end
        end else if (state_reg == WAIT_HI) begin
            wcnt_next = wcnt_reg;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            last_ch_reg   <= ADC_AW'(NUM_CH - 1);
            strobe_reg    <= 1'b0;
            oe_reg        <= 1'b0;
            res_valid_reg <= 1'b0;
            res_ch_reg    <= '0;
            res_data_reg  <= '0;
            busy_reg      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) regfile_reg[i] <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            last_ch_reg   <= last_ch_next;
            strobe_reg    <= strobe_next;
            oe_reg        <= oe_next;
            res_valid_reg <= res_valid_next;
            res_ch_reg    <= res_ch_next;
            res_data_reg  <= res_data_next;
            busy_reg      <= (state_next != IDLE);
            if (wr_en) regfile_reg[addr_reg] <= data_in;
        end
    end

`ifdef ADC_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_reg <= '0;
            tmo_reg  <= 1'b0;
        end else begin
            wcnt_reg <= wcnt_next;
            tmo_reg  <= tmo_next;
        end
    end
    assign timeout_err = tmo_reg;
`else
    assign timeout_err = tmo_next;
`endif

    assign addr      = addr_reg;
    assign ale       = strobe_reg;
    assign start     = strobe_reg;
    assign oe        = oe_reg;
    assign res_valid = res_valid_reg;
    assign res_ch    = res_ch_reg;
    assign res_data  = res_data_reg;
    assign busy      = busy_reg;
    assign rd_data   = regfile_reg[rd_ch];
endmodule
